// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU writeback path
//   and the load writeback path. Each source feeds a small FIFO. One head per
//   cycle is granted onto the write port. When both heads target the same
//   register, the older write goes first. Otherwise the two sources alternate
//   round-robin. Writes to x0 are consumed and dropped. The hazard output tells
//   decode that a source register still has a write in flight.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   alu_valid/ready/rd/data  ALU writeback request channel
//   mem_valid/ready/rd/data  load writeback request channel
//   rd, write_data, reg_write  registered register-file write port
//   chk_rs1, chk_rs2      decode source indices to check
//   hazard                combinational pending-write indication
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] write_data,
    output logic            reg_write,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            hazard
);

    localparam int NSRC = 2;                 // index 0 = ALU, 1 = load
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    // At most 2*DEPTH entries are outstanding, so this width keeps the
    // modular age comparison unambiguous.
    localparam int SW   = (DEPTH <= 2) ? 3 : $clog2(2 * DEPTH) + 2;

    // Queue storage, one FIFO per source
    logic [AW-1:0]   q_rd_r    [NSRC][DEPTH];
    logic [XLEN-1:0] q_data_r  [NSRC][DEPTH];
    logic [SW-1:0]   q_stamp_r [NSRC][DEPTH];
    logic            q_vld_r   [NSRC][DEPTH];
    logic [PW-1:0]   wr_ptr_r  [NSRC];
    logic [PW-1:0]   rd_ptr_r  [NSRC];
    logic [CW-1:0]   cnt_r     [NSRC];
    logic [SW-1:0]   stamp_r;
    logic            rr_r;                   // 0: ALU wins next tie, 1: load wins

    logic            in_valid_s [NSRC];
    logic [AW-1:0]   in_rd_s    [NSRC];
    logic [XLEN-1:0] in_data_s  [NSRC];
    logic            ready_s    [NSRC];
    logic [NSRC-1:0] push_s;
    logic [NSRC-1:0] pop_s;
    logic            nonempty_s [NSRC];
    logic [AW-1:0]   head_rd_s    [NSRC];
    logic [XLEN-1:0] head_data_s  [NSRC];
    logic [SW-1:0]   head_stamp_s [NSRC];
    logic [SW-1:0]   stamp_diff_s;
    logic            alu_older_s;
    logic            grant_vld_s;
    logic            grant_src_s;
    logic            rr_adv_s;
    logic            hit1_s;
    logic            hit2_s;

    assign in_valid_s[0] = alu_valid;
    assign in_valid_s[1] = mem_valid;
    assign in_rd_s[0]    = alu_rd;
    assign in_rd_s[1]    = mem_rd;
    assign in_data_s[0]  = alu_data;
    assign in_data_s[1]  = mem_data;
    assign alu_ready     = ready_s[0];
    assign mem_ready     = ready_s[1];

    // Per-source readiness, head view and accepted-push decode
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            ready_s[s]      = (cnt_r[s] != CW'(DEPTH));
            nonempty_s[s]   = (cnt_r[s] != {CW{1'b0}});
            head_rd_s[s]    = q_rd_r[s][rd_ptr_r[s]];
            head_data_s[s]  = q_data_r[s][rd_ptr_r[s]];
            head_stamp_s[s] = q_stamp_r[s][rd_ptr_r[s]];
            // x0 requests are handshaken but never stored
            push_s[s]       = in_valid_s[s] & ready_s[s] & (in_rd_s[s] != {AW{1'b0}});
        end
    end

    // Modular age compare: negative difference means the ALU head is older;
    // equal stamps resolve to the load head.
    assign stamp_diff_s = head_stamp_s[0] - head_stamp_s[1];
    assign alu_older_s  = stamp_diff_s[SW-1];

    // Grant selection from the queue heads
    always_comb begin
        grant_vld_s = 1'b0;
        grant_src_s = 1'b0;
        rr_adv_s    = 1'b0;
        if (nonempty_s[0] && nonempty_s[1]) begin
            grant_vld_s = 1'b1;
            if (head_rd_s[0] == head_rd_s[1]) begin
                grant_src_s = ~alu_older_s;
                rr_adv_s    = 1'b0;
            end else begin
                grant_src_s = rr_r;
                rr_adv_s    = 1'b1;
            end
        end else if (nonempty_s[0]) begin
            grant_vld_s = 1'b1;
            grant_src_s = 1'b0;
        end else if (nonempty_s[1]) begin
            grant_vld_s = 1'b1;
            grant_src_s = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_src_s = 1'b0;
        end
        pop_s[0] = grant_vld_s & ~grant_src_s;
        pop_s[1] = grant_vld_s &  grant_src_s;
    end

    // Pending-write check against queued entries and the write port
    always_comb begin
        hit1_s = reg_write & (rd == chk_rs1);
        hit2_s = reg_write & (rd == chk_rs2);
        for (int s = 0; s < NSRC; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit1_s = hit1_s | (q_vld_r[s][i] & (q_rd_r[s][i] == chk_rs1));
                hit2_s = hit2_s | (q_vld_r[s][i] & (q_rd_r[s][i] == chk_rs2));
            end
        end
        hazard = (hit1_s & (chk_rs1 != {AW{1'b0}})) | (hit2_s & (chk_rs2 != {AW{1'b0}}));
    end

    // Queue state: pointers, occupancy and entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr_r[s] <= {PW{1'b0}};
                rd_ptr_r[s] <= {PW{1'b0}};
                cnt_r[s]    <= {CW{1'b0}};
                for (int i = 0; i < DEPTH; i++) begin
                    q_rd_r[s][i]    <= {AW{1'b0}};
                    q_data_r[s][i]  <= {XLEN{1'b0}};
                    q_stamp_r[s][i] <= {SW{1'b0}};
                    q_vld_r[s][i]   <= 1'b0;
                end
            end
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                // Pop and push never touch the same slot: pop needs non-empty,
                // push needs not-full, and the pointers only meet at those limits.
                if (pop_s[s]) begin
                    q_vld_r[s][rd_ptr_r[s]] <= 1'b0;
                    rd_ptr_r[s]             <= rd_ptr_r[s] + PW'(1'b1);
                end
                if (push_s[s]) begin
                    q_rd_r[s][wr_ptr_r[s]]    <= in_rd_s[s];
                    q_data_r[s][wr_ptr_r[s]]  <= in_data_s[s];
                    q_stamp_r[s][wr_ptr_r[s]] <= stamp_r;
                    q_vld_r[s][wr_ptr_r[s]]   <= 1'b1;
                    wr_ptr_r[s]               <= wr_ptr_r[s] + PW'(1'b1);
                end
                cnt_r[s] <= cnt_r[s] + CW'(push_s[s]) - CW'(pop_s[s]);
            end
        end
    end

    // Arrival stamp and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_r <= {SW{1'b0}};
            rr_r    <= 1'b0;
        end else begin
            if (|push_s) begin
                stamp_r <= stamp_r + SW'(1'b1);
            end
            if (rr_adv_s) begin
                rr_r <= ~rr_r;
            end
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd         <= {AW{1'b0}};
            write_data <= {XLEN{1'b0}};
            reg_write  <= 1'b0;
        end else begin
            reg_write <= grant_vld_s;
            if (grant_vld_s) begin
                rd         <= head_rd_s[grant_src_s];
                write_data <= head_data_s[grant_src_s];
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd, write_data, reg_write) between two writeback sources: the ALU result path and the load/memory path.
- Each source has a small queue. An age-aware round-robin arbiter drains one entry per cycle onto the write port.
- Writes to x0 are dropped.
- A pending-write check lets decode stall reads whose source register still has a write in flight.

Parameters:
XLEN, 64, data width of write_data and queued entries
AW, 5, register index width (32 registers)
DEPTH, 2, entries per source queue (power of 2, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU queue not full
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load queue not full
mem_rd  input  AW  load destination register
mem_data  input  XLEN  load data
rd  output  AW  register-file write index
write_data  output  XLEN  register-file write data
reg_write  output  1  register-file write enable, one cycle per write
chk_rs1  input  AW  decode source 1 index
chk_rs2  input  AW  decode source 2 index
hazard  output  1  chk_rs1 or chk_rs2 has a pending write

Behaviour:
Reset:
- rst_n low immediately clears both queues, the age counter and the rr pointer (rr=ALU first).
- Outputs under reset: rd=0, write_data=0, reg_write=0, hazard=0, alu_ready=1, mem_ready=1.
- Reset mid-operation discards all queued writes.

Accept:
- A transfer occurs on a rising edge with X_valid & X_ready.
- X_ready = queue X not full; it is combinational from occupancy only, never from X_valid.
- An accepted request with rd==0 is consumed but not enqueued.
- Each enqueued entry stores {rd, data, stamp}.
- stamp is a 3-bit global arrival counter, incremented once per cycle in which any entry is enqueued.
- When both sources enqueue in the same cycle, they get the same stamp; the mem entry is treated as older.

Grant (each cycle, combinational from the queue heads):
- Neither queue non-empty: no grant.
- One queue non-empty: grant it.
- Both non-empty and heads have equal rd: grant the older head. Older means the smaller stamp under modular comparison (diff = stamp_a - stamp_b, MSB set means a is older); equal stamps mean mem is older.
- Both non-empty, different rd: grant by round-robin pointer, then move the pointer to the other source.
- The pointer changes only on a round-robin grant.

Write port:
- The granted head is popped at the clock edge and registered into rd/write_data with reg_write=1 for exactly one cycle.
- reg_write=0 on cycles with no grant; rd/write_data hold their last values.
- Latency from accept to reg_write is 1 cycle minimum (enqueue at edge N, grant in cycle N, reg_write high after edge N+1).
- Throughput is 1 write per cycle.
- The block never issues two writes in one cycle.

Boundary conditions:
- Full queue: a pop and an accept in the same edge are allowed only if ready was already high. Ready is computed before the pop, so a full queue stays not-ready for that cycle.
- Queue pointers wrap modulo DEPTH.
- Outstanding entries never exceed 2*DEPTH, so the 3-bit stamp comparison is safe for DEPTH<=2. For larger DEPTH, stamp width = clog2(2*DEPTH)+2.

Hazard:
- hazard=1 when a nonzero chk_rs1 or chk_rs2 equals the rd of any valid queue entry, or equals the output register while reg_write=1.
- hazard is combinational.
- chk index 0 never raises hazard.

Test Plan:
- Reset then idle: hold rst_n=0 → reg_write=0, alu_ready=mem_ready=1, hazard=0. Assert rst_n=0 mid-queue → queues flushed, no further reg_write.
- Single ALU write: alu rd=1, data=100 for one cycle → next cycle reg_write=1, rd=1, write_data=100, then reg_write=0.
- Round-robin, different rd: same cycle alu rd=2 data=200 and mem rd=3 data=300 → writes on consecutive cycles, rd=2 first (rr=ALU after reset), then rd=3. Repeat with alu rd=4, mem rd=5 → rd=5 first.
- Same rd ordering: alu rd=1 data=500 and mem rd=1 data=400 in same cycle → rd=1/400 written, then rd=1/500. Alternative: mem rd=6 data=1 at cycle N, alu rd=6 data=2 at N+1 with the queues backed up → data 1 written before data 2.
- Full/backpressure: hold alu_valid=1 with rd=7..10 while mem is also saturated → alu_ready drops after DEPTH outstanding; nothing lost or duplicated; all writes appear in per-source FIFO order.
- x0 and hazard: alu rd=0 data=999 → no reg_write. Queue mem rd=8 with chk_rs1=8 → hazard=1 until the cycle after reg_write for rd=8. chk_rs2=0 → hazard stays 0.
